// File: rtl/tt_um_rom_stream_tx_pkg.sv
// Shared definitions for the ROM stream transmitter: FSM states, uio bit
// positions and the output-enable pattern.
package tt_um_rom_stream_tx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    ACK     = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned STB_ADDR = 0;
  localparam int unsigned STB_DATA = 1;
  localparam int unsigned START    = 2;
  localparam int unsigned READY    = 3;
  localparam int unsigned LOOP     = 4;
  localparam int unsigned VALID    = 5;
  localparam int unsigned BUSY     = 6;
  localparam int unsigned DONE_BIT = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hE0;
  localparam int unsigned CW = 9;

  // A length of zero means a full 256-byte pass.
  function automatic logic [CW-1:0] len_to_cnt(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/tt_um_rom_stream_tx_if.sv
// TT user-project pin bundle; master drives the inputs, slave is the design.
interface tt_um_rom_stream_tx_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_rom_stream_tx_sync_edge.sv
// Multi-flop input synchronizer producing the synchronized level and a
// one-clock pulse on its rising edge.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[SYNC_STAGES-2:0], din};
      prev <= sr[SYNC_STAGES-1];
    end
  end

  assign level = sr[SYNC_STAGES-1];
  assign rise  = sr[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/tt_um_rom_stream_tx.sv
// Byte buffer loaded over pins, streamed out with a 4-phase valid/ready
// handshake; optional looping and abort on a fresh start strobe.
module tt_um_rom_stream_tx
  import tt_um_rom_stream_tx_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  tt_um_rom_stream_tx_if.slave tt
);

  logic [4:0] lvl;
  logic [4:0] rise;

  for (genvar g = 0; g < 5; g++) begin : g_sync
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (tt.uio_in[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  logic addr_p, data_p, start_p, ready_s, loop_s;
  assign addr_p  = rise[STB_ADDR];
  assign data_p  = rise[STB_DATA];
  assign start_p = rise[START];
  assign ready_s = lvl[READY];
  assign loop_s  = lvl[LOOP];

  logic unused_ok;
  assign unused_ok = &{1'b0, tt.ena, tt.uio_in[7:5], lvl[2:0], rise[4:3]};

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [7:0]      len;
  logic [7:0]      uo_q;
  logic            valid_q, busy_q, done_q;
  logic            mem_we;
  logic [7:0]      mem [2**AW];

  // Address strobe takes priority; data strobe in the same clock is dropped.
  assign mem_we = (state == IDLE) && data_p && !addr_p;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= tt.ui_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      len     <= '0;
      uo_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_p)      wr_ptr <= AW'(tt.ui_in);
          else if (data_p) wr_ptr <= wr_ptr + 1'b1;
          if (start_p) begin
            len     <= tt.ui_in;
            cnt     <= len_to_cnt(tt.ui_in);
            rd_ptr  <= '0;
            uo_q    <= mem[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (start_p) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else if (ready_s) begin
            valid_q <= 1'b0;
            rd_ptr  <= rd_ptr + 1'b1;
            cnt     <= cnt - 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          if (start_p) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (!ready_s) begin
            if (cnt != '0) begin
              uo_q    <= mem[rd_ptr];
              valid_q <= 1'b1;
              state   <= PRESENT;
            end else if (loop_s) begin
              rd_ptr  <= '0;
              cnt     <= len_to_cnt(len);
              uo_q    <= mem[0];
              valid_q <= 1'b1;
              state   <= PRESENT;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    tt.uio_out           = '0;
    tt.uio_out[VALID]    = valid_q;
    tt.uio_out[BUSY]     = busy_q;
    tt.uio_out[DONE_BIT] = done_q;
  end

  assign tt.uo_out = uo_q;
  assign tt.uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_rom_stream_tx.sv
// Directed bench for tt_um_rom_stream_tx: load, stream, length-0, loop/abort,
// strobe corner cases and reset mid-stream, against a bench-side buffer model.
module tb_tt_um_rom_stream_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  tt_um_rom_stream_tx_if bus ();

  tt_um_rom_stream_tx #(.AW(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [7:0] model [256];
  logic [7:0] wp;
  logic [7:0] b;
  int d0;

  always @(posedge clk) if (bus.uio_out[7] === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int bitn);
    @(negedge clk) bus.uio_in[bitn] = 1'b1;
    repeat (4) @(negedge clk);
    bus.uio_in[bitn] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_addr(input logic [7:0] a);
    bus.ui_in = a;
    pulse(0);
    wp = a;
  endtask

  task automatic write_byte(input logic [7:0] d);
    bus.ui_in = d;
    pulse(1);
    model[wp] = d;
    wp = wp + 8'd1;
  endtask

  task automatic recv(output logic [7:0] byte_o);
    int t;
    t = 0;
    while (bus.uio_out[5] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk("valid_rise", {15'd0, bus.uio_out[5]}, 16'd1);
    byte_o = bus.uo_out;
    repeat (2) @(negedge clk);
    bus.uio_in[3] = 1'b1;
    t = 0;
    while (bus.uio_out[5] !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    chk("valid_fall", {15'd0, bus.uio_out[5]}, 16'd0);
    repeat (2) @(negedge clk);
    bus.uio_in[3] = 1'b0;
  endtask

  task automatic run_stream(input logic [7:0] len, input int nbytes);
    int t;
    d0 = done_cnt;
    bus.ui_in = len;
    pulse(2);
    for (int i = 0; i < nbytes; i++) begin
      recv(b);
      chk($sformatf("byte[%0d]", i), {8'd0, b}, {8'd0, model[i % 256]});
    end
    t = 0;
    while (done_cnt == d0 && t < 30) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    chk("done_pulses", 16'(done_cnt - d0), 16'd1);
    chk("busy_after", {15'd0, bus.uio_out[6]}, 16'd0);
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    wp = 8'h00;

    // Asynchronous reset seen without any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_uo_out", {8'd0, bus.uo_out}, 16'h0000);
    chk("rst_uio_out", {8'd0, bus.uio_out}, 16'h0000);
    chk("rst_uio_oe", {8'd0, bus.uio_oe}, 16'h00E0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Three-byte stream.
    set_addr(8'h00);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    run_stream(8'h03, 3);

    // Fill mem[i]=i via auto-increment (wraps to 00), then patch 10/11.
    set_addr(8'h00);
    for (int i = 0; i < 256; i++) write_byte(8'(i));
    set_addr(8'h10);
    write_byte(8'hA5);
    write_byte(8'h5A);
    run_stream(8'h00, 256);

    // Address and data strobes together: only the pointer moves.
    bus.ui_in = 8'h40;
    @(negedge clk) bus.uio_in[1:0] = 2'b11;
    repeat (4) @(negedge clk);
    bus.uio_in[1:0] = 2'b00;
    repeat (4) @(negedge clk);
    wp = 8'h40;
    write_byte(8'h77);

    // Data strobe while busy is ignored; then reset mid-PRESENT.
    bus.ui_in = 8'h00;
    pulse(2);
    bus.ui_in = 8'hEE;
    pulse(1);
    for (int i = 0; i < 3; i++) begin
      recv(b);
      chk("pre_rst_byte", {8'd0, b}, {8'd0, model[i]});
    end
    for (int t = 0; t < 100 && bus.uio_out[5] !== 1'b1; t++) @(negedge clk);
    chk("valid_before_rst", {15'd0, bus.uio_out[5]}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_uo_out", {8'd0, bus.uo_out}, 16'h0000);
    chk("midrst_uio_out", {8'd0, bus.uio_out}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wp = 8'h00;
    repeat (2) @(negedge clk);
    run_stream(8'h42, 66);

    // Loop then abort.
    set_addr(8'h00);
    write_byte(8'h11);
    write_byte(8'h22);
    bus.uio_in[4] = 1'b1;
    d0 = done_cnt;
    bus.ui_in = 8'h02;
    pulse(2);
    for (int i = 0; i < 5; i++) begin
      recv(b);
      chk("loop_byte", {8'd0, b}, (i % 2 == 0) ? 16'h0011 : 16'h0022);
    end
    for (int t = 0; t < 100 && bus.uio_out[5] !== 1'b1; t++) @(negedge clk);
    chk("loop_6th", {8'd0, bus.uo_out}, 16'h0022);
    @(negedge clk) bus.uio_in[2] = 1'b1;
    for (int t = 0; t < 10 && bus.uio_out[6] !== 1'b0; t++) @(negedge clk);
    chk("abort_busy", {15'd0, bus.uio_out[6]}, 16'd0);
    chk("abort_valid", {15'd0, bus.uio_out[5]}, 16'd0);
    repeat (4) @(negedge clk);
    bus.uio_in[2] = 1'b0;
    bus.uio_in[4] = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_uo_hold", {8'd0, bus.uo_out}, 16'h0022);
    chk("abort_no_done", 16'(done_cnt - d0), 16'd0);
    chk("abort_idle_busy", {15'd0, bus.uio_out[6]}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
